// File: rtl/finite_logarithm.sv
// finite_logarithm: sequential discrete logarithm over GF(2^M).
// Given a nonzero standard-basis element x, finds k with alpha^k == x by
// walking a running power of alpha and testing STEPS candidate exponents
// per cycle. A zero input is reported as an error one edge after capture.
//
// Handshake: start is a one-cycle request that captures standard_in. valid
// is a one-cycle pulse. log_out and error hold until the next result. A new
// start while busy abandons the current search without a valid pulse.
module finite_logarithm #(
    parameter int M     = 4,
    parameter int STEPS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [M-1:0] standard_in,
    output logic         busy,
    output logic         valid,
    output logic         error,
    output logic [M-1:0] log_out
);

    // Primitive field polynomial per degree, including the x^M term.
    function automatic int bch_polynomial(input int m);
        case (m)
            2:       return 'h7;
            3:       return 'hB;
            4:       return 'h13;
            5:       return 'h25;
            6:       return 'h43;
            7:       return 'h89;
            8:       return 'h11D;
            9:       return 'h211;
            10:      return 'h409;
            11:      return 'h805;
            12:      return 'h1053;
            13:      return 'h201B;
            14:      return 'h4443;
            15:      return 'h8003;
            16:      return 'h1100B;
            default: return 'h13;
        endcase
    endfunction

    // The exponent counter carries one extra bit so e+j never wraps before
    // it is compared against the largest legal exponent 2^M-2.
    localparam int            EW       = M + 1;
    localparam int            POLY     = bch_polynomial(M);
    localparam logic [M-1:0]  POLY_LOW = POLY[M-1:0];
    localparam logic [EW-1:0] MAX_EXP  = EW'((1 << M) - 2);
    localparam logic [M-1:0]  ONE      = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ZERO   = 2'd1,  // zero captured, error result due next edge
        ST_SEARCH = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [M-1:0]    target_q, target_n;
    logic [M-1:0]    pow_q, pow_n;
    logic [EW-1:0]   exp_q, exp_n;
    logic            valid_n;
    logic            error_n;
    logic [M-1:0]    log_n;

    logic            hit;
    logic [M-1:0]    hit_exp;
    logic [M-1:0]    pow_step;

    // Multiply by alpha: shift up one degree and fold x^M back in.
    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY_LOW : {M{1'b0}});
    endfunction

    // Walk the STEPS candidates r*alpha^j, pick the smallest in-range match,
    // and leave r*alpha^STEPS as the next running power.
    always_comb begin : search_comb
        logic [M-1:0]  cand;
        logic [EW-1:0] e_j;
        cand     = pow_q;
        e_j      = exp_q;
        hit      = 1'b0;
        hit_exp  = '0;
        for (int j = 0; j < STEPS; j++) begin
            e_j = exp_q + EW'(j);
            if (!hit && (e_j <= MAX_EXP) && (cand == target_q)) begin
                hit     = 1'b1;
                hit_exp = e_j[M-1:0];
            end
            cand = mul_alpha(cand);
        end
        pow_step = cand;
    end

    // Next-state and next-output logic; a start always wins over the
    // outcome of the current cycle's search.
    always_comb begin
        state_n  = state_q;
        target_n = target_q;
        pow_n    = pow_q;
        exp_n    = exp_q;
        valid_n  = 1'b0;
        error_n  = error;
        log_n    = log_out;

        case (state_q)
            ST_IDLE: begin
            end
            ST_ZERO: begin
                valid_n = 1'b1;
                error_n = 1'b1;
                log_n   = '0;
                state_n = ST_IDLE;
            end
            ST_SEARCH: begin
                if (hit) begin
                    valid_n = 1'b1;
                    error_n = 1'b0;
                    log_n   = hit_exp;
                    state_n = ST_IDLE;
                end else begin
                    pow_n = pow_step;
                    exp_n = exp_q + EW'(STEPS);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (start) begin
            // An in-flight search is dropped silently, even on a match edge.
            if (state_q == ST_SEARCH) begin
                valid_n = 1'b0;
                error_n = error;
                log_n   = log_out;
            end
            target_n = standard_in;
            pow_n    = ONE;
            exp_n    = '0;
            state_n  = (standard_in == '0) ? ST_ZERO : ST_SEARCH;
        end
    end

    // State and result registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            pow_q    <= '0;
            exp_q    <= '0;
            valid    <= 1'b0;
            error    <= 1'b0;
            log_out  <= '0;
        end else begin
            state_q  <= state_n;
            target_q <= target_n;
            pow_q    <= pow_n;
            exp_q    <= exp_n;
            valid    <= valid_n;
            error    <= error_n;
            log_out  <= log_n;
        end
    end

    assign busy = (state_q == ST_SEARCH);

endmodule

// File: tb/tb_finite_logarithm.sv
// Bench for finite_logarithm over GF(16), x^4+x+1. Five instances with
// STEPS = 1,2,3,4,15 share one stimulus stream; a request-level model
// predicts when each result appears and what it holds.
module tb_finite_logarithm;

  localparam int N_INST = 5;
  localparam int STEPS_TAB [N_INST] = '{1, 2, 3, 4, 15};
  // alpha^i for i = 0..14 in GF(16) with x^4+x+1, worked by hand.
  localparam logic [3:0] ALPHA_POW [15] =
    '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
      4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [3:0] standard_in = 4'h0;

  always #5 clk = ~clk;

  logic busy [N_INST];
  logic valid [N_INST];
  logic error [N_INST];
  logic [3:0] log_out [N_INST];

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    finite_logarithm #(.M(4), .STEPS(STEPS_TAB[g])) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .standard_in (standard_in),
      .busy        (busy[g]),
      .valid       (valid[g]),
      .error       (error[g]),
      .log_out     (log_out[g])
    );
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  function automatic int log_of(input int x);
    for (int i = 0; i < 15; i++) if (int'(ALPHA_POW[i]) == x) return i;
    return -1;
  endfunction

  function automatic int alpha_of(input int l);
    if (l >= 0 && l < 15) return int'(ALPHA_POW[l]);
    return -1;
  endfunction

  // ---------------- request-level model ----------------
  int cyc = 0;
  bit m_pend [N_INST];
  bit m_zero [N_INST];
  int m_due [N_INST];
  int m_k [N_INST];
  int m_x [N_INST];
  bit m_valid [N_INST];
  bit m_err [N_INST];
  int m_log [N_INST];
  int m_res_x [N_INST];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < N_INST; g++) begin
        m_pend[g] = 1'b0; m_zero[g] = 1'b0; m_due[g] = 0; m_k[g] = 0;
        m_x[g] = 0; m_valid[g] = 1'b0; m_err[g] = 1'b0; m_log[g] = 0;
        m_res_x[g] = 0;
      end
    end else begin
      cyc++;
      for (int g = 0; g < N_INST; g++) begin
        m_valid[g] = 1'b0;
        // A result appears on its due edge unless a new start cuts a search short.
        if (m_pend[g] && cyc == m_due[g] && !(start && !m_zero[g])) begin
          m_valid[g] = 1'b1;
          m_err[g]   = m_zero[g];
          m_log[g]   = m_zero[g] ? 0 : m_k[g];
          m_res_x[g] = m_x[g];
          m_pend[g]  = 1'b0;
        end
        if (start) begin
          m_pend[g] = 1'b1;
          m_x[g]    = int'(standard_in);
          m_zero[g] = (standard_in == 4'h0);
          m_k[g]    = m_zero[g] ? 0 : log_of(int'(standard_in));
          m_due[g]  = cyc + (m_zero[g] ? 1 : (m_k[g] / STEPS_TAB[g] + 1));
        end
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (!reset) begin
      for (int g = 0; g < N_INST; g++) begin
        check($sformatf("s%0d_valid@%0d", STEPS_TAB[g], cyc), int'(valid[g]), int'(m_valid[g]));
        check($sformatf("s%0d_busy@%0d", STEPS_TAB[g], cyc), int'(busy[g]),
              int'(m_pend[g] && !m_zero[g]));
        check($sformatf("s%0d_error@%0d", STEPS_TAB[g], cyc), int'(error[g]), int'(m_err[g]));
        check($sformatf("s%0d_log@%0d", STEPS_TAB[g], cyc), int'(log_out[g]), m_log[g]);
        if (valid[g] && !error[g])
          check($sformatf("s%0d_alpha_pow_log@%0d", STEPS_TAB[g], cyc),
                alpha_of(int'(log_out[g])), m_res_x[g]);
      end
    end
  end

  // ---------------- driver ----------------
  // Called on a negedge; returns on the following negedge (cycle 0 of the request).
  task automatic do_start(input logic [3:0] x);
    start = 1'b1;
    standard_in = x;
    @(negedge clk);
    start = 1'b0;
    standard_in = 4'($urandom_range(0, 15));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    for (int g = 0; g < N_INST; g++) begin
      check($sformatf("reset_valid_s%0d", STEPS_TAB[g]), int'(valid[g]), 0);
      check($sformatf("reset_busy_s%0d", STEPS_TAB[g]), int'(busy[g]), 0);
      check($sformatf("reset_log_s%0d", STEPS_TAB[g]), int'(log_out[g]), 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Zero input: error pulse in cycle 1, never busy.
    do_start(4'h0);
    check("zero_busy_c0", int'(busy[0]), 0);
    @(negedge clk);
    check("zero_valid_c1", int'(valid[0]), 1);
    check("zero_error_c1", int'(error[0]), 1);
    check("zero_log_c1", int'(log_out[0]), 0);
    repeat (3) @(negedge clk);

    // Identity element.
    do_start(4'h1);
    @(negedge clk);
    check("one_valid_c1", int'(valid[0]), 1);
    check("one_log_c1", int'(log_out[0]), 0);
    check("one_error_c1", int'(error[0]), 0);
    repeat (3) @(negedge clk);

    // alpha^4 = 0011.
    do_start(4'h3);
    repeat (4) @(negedge clk);
    check("a4_no_valid_c4", int'(valid[0]), 0);
    @(negedge clk);
    check("a4_valid_c5", int'(valid[0]), 1);
    check("a4_log_c5", int'(log_out[0]), 4);
    repeat (3) @(negedge clk);

    // Worst case alpha^14 = 1001 across STEPS.
    do_start(4'h9);
    @(negedge clk);
    check("a14_s15_valid_c1", int'(valid[4]), 1);
    check("a14_s15_log_c1", int'(log_out[4]), 14);
    repeat (3) @(negedge clk);
    check("a14_s4_valid_c4", int'(valid[3]), 1);
    check("a14_s4_log_c4", int'(log_out[3]), 14);
    repeat (11) @(negedge clk);
    check("a14_s1_valid_c15", int'(valid[0]), 1);
    check("a14_s1_log_c15", int'(log_out[0]), 14);
    repeat (3) @(negedge clk);

    // Restart while busy: first request dropped, second (alpha^1) answered.
    do_start(4'h9);
    repeat (3) @(negedge clk);
    do_start(4'h2);
    @(negedge clk);
    check("restart_no_valid_c1", int'(valid[0]), 0);
    @(negedge clk);
    check("restart_valid_c2", int'(valid[0]), 1);
    check("restart_log_c2", int'(log_out[0]), 1);
    repeat (16) @(negedge clk);

    // Back-to-back: new start in the cycle the previous result is valid.
    do_start(4'h3);
    repeat (5) @(negedge clk);
    check("b2b_first_valid", int'(valid[0]), 1);
    check("b2b_first_log", int'(log_out[0]), 4);
    do_start(4'h9);
    repeat (15) @(negedge clk);
    check("b2b_second_valid", int'(valid[0]), 1);
    check("b2b_second_log", int'(log_out[0]), 14);
    repeat (3) @(negedge clk);

    // Reset in the middle of a search: outputs clear at once, no pulse later.
    do_start(4'h9);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy[0]), 0);
    check("midrst_valid", int'(valid[0]), 0);
    check("midrst_error", int'(error[0]), 0);
    check("midrst_log", int'(log_out[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Exhaustive sweep over nonzero elements (model checks every cycle).
    for (int x = 1; x < 16; x++) begin
      do_start(4'(x));
      repeat (16) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/finite_logarithm.md
Name: finite_logarithm

Overview:
- Sequential GF(2^M) discrete logarithm: the inverse direction of the `lpow` / parallel_standard_power path.
- Given a nonzero standard-basis element x, returns the binary exponent k, 0 <= k <= 2^M-2, such that alpha^k = x.
- Searches by stepping an LFSR-style running power of alpha, comparing STEPS candidates per cycle.
- Used by decoder post-processing (error-locator root to bit position) and by debug/verification logic.

Parameters:
- M, 4, field degree; the field polynomial is `BCH_POLYNOMIAL(M)`, which is primitive.
- STEPS, 1, candidate exponents compared per cycle; 1 <= STEPS <= 2^M-1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  one-cycle request; captures standard_in
- standard_in  input  M  element x, standard basis; sampled only when start=1
- busy  output  1  search in progress
- valid  output  1  one-cycle pulse; log_out/error are valid
- error  output  1  x was zero (log undefined); held with log_out
- log_out  output  M  exponent k, unsigned binary

Behaviour:
- Reset (async, active-high): busy=0, valid=0, error=0, log_out=0. Internal target, running power and exponent counter are cleared. Reset overrides start.
- State IDLE (busy=0):
  - start with standard_in!=0: capture target, running power r=1 (alpha^0), exponent counter e=0, busy<=1.
  - start with standard_in==0: next edge gives valid=1, error=1, log_out=0, busy stays 0. No search.
- State SEARCH (busy=1), each cycle:
  - Form candidates c_j = r*alpha^j for j=0..STEPS-1 as constant multiplies. Candidates with e+j > 2^M-2 are masked off.
  - If any unmasked c_j == target, take the smallest such j. Next edge: log_out<=e+j, error<=0, valid<=1, busy<=0.
  - Otherwise: r <= r*alpha^STEPS (constant multiply), e <= e+STEPS.
- Because the polynomial is primitive, a nonzero target always matches by e <= 2^M-2. No timeout state is needed.
- Latency, with start sampled at edge 0:
  - valid is high in cycle floor(k/STEPS)+1 after the start cycle.
  - Zero input: valid in cycle 1.
  - Worst case: ceil((2^M-1)/STEPS) cycles.
- valid is a single-cycle pulse. log_out and error hold their values until the next result is produced.
- start while busy: the current search is abandoned without a valid pulse. The new input is captured and the search restarts from e=0 (or reports zero-error as above).
- start in the same cycle valid is asserted: the result pulse still completes, and the new request is accepted.
- Exponent counter width is M+1 bits internally, to avoid overflow when e+j is compared against 2^M-2. log_out is the low M bits.
- e wrap-around never occurs: the search always terminates first.

Test Plan:
- Conditions: M=4, poly x^4+x+1, STEPS=1 unless stated.
- Zero input: start with standard_in=0000 -> cycle 1 after start: valid=1, error=1, log_out=0; busy never asserted.
- Identity and small exponent: x=0001 -> valid in cycle 1, log_out=0, error=0. x=0011 (alpha^4) -> valid in cycle 5, log_out=4.
- Worst case and STEPS: x=1001 (alpha^14) -> STEPS=1 gives valid in cycle 15, log_out=14. STEPS=4 gives valid in cycle 4, log_out=14. STEPS=15 gives valid in cycle 1.
- Restart and reset mid-operation:
  - start x=1001, then at cycle 3 start x=0010 -> no pulse for the first request; valid 2 cycles after the second start with log_out=1.
  - Assert reset at cycle 5 of a search -> all outputs 0 immediately, no valid pulse.
- Exhaustive sweep: all 15 nonzero x for STEPS in {1,2,3,4,15}. Check alpha^log_out == x against a reference model, latency == floor(k/STEPS)+1, and exactly one valid pulse per request.
- Back-to-back: start asserted in the same cycle as valid -> previous result is correct, new result follows with correct latency.
